// File: rtl/chain_exerciser.sv
// Drives a toggle (or optional LFSR) pattern into a 2-cycle delay-chain stage and counts returned mismatches.
// Optional feature: define CHAIN_EXERCISER_LFSR_EN to add the 8-bit LFSR pattern selected by mode=1.
module chain_exerciser #(
  parameter int LEN = 256,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          test_sel,
  input  logic          mode,
  output logic          din,
  output logic          test,
  input  logic          dout,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_count,
  output logic          pass
);

  localparam int NW = $clog2(LEN + 3);
  // RUN spans a load cycle plus LEN emit cycles; DRAIN then spans two more.
  localparam logic [NW-1:0] RUN_LAST   = NW'(LEN);
  localparam logic [NW-1:0] DRAIN_LAST = NW'(LEN + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_next;
  logic [NW-1:0] cnt;
  logic          accept;
  logic          emit;
  logic          tog;
  logic          pat_bit;
  logic          din_vld;
  logic [1:0]    exp_sr;
  logic [1:0]    vld_sr;

`ifdef CHAIN_EXERCISER_LFSR_EN
  logic       mode_lat;
  logic [7:0] lfsr;
  logic       lfsr_fb;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a right-shifting register.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4];
  assign pat_bit = mode_lat ? lfsr[0] : tog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_lat <= 1'b0;
      lfsr     <= 8'h01;
    end else if (accept) begin
      mode_lat <= mode;
      lfsr     <= 8'h01;
    end else if (emit) begin
      lfsr <= {lfsr_fb, lfsr[7:1]};
    end
  end
`else
  logic mode_unused;
  assign mode_unused = mode;
  assign pat_bit     = tog;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign emit   = (state == RUN) && (cnt != RUN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == RUN_LAST) state_next = DRAIN;
      DRAIN:   if (cnt == DRAIN_LAST) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      test      <= 1'b0;
      tog       <= 1'b1;
      din       <= 1'b0;
      din_vld   <= 1'b0;
      exp_sr    <= '0;
      vld_sr    <= '0;
      err_count <= '0;
    end else begin
      exp_sr <= {exp_sr[0], din};
      vld_sr <= {vld_sr[0], din_vld};
      if (accept) begin
        cnt       <= '0;
        test      <= test_sel;
        tog       <= 1'b1;
        din       <= 1'b0;
        din_vld   <= 1'b0;
        err_count <= '0;
      end else begin
        if (state == RUN || state == DRAIN) cnt <= cnt + 1'b1;
        din     <= emit ? pat_bit : 1'b0;
        din_vld <= emit;
        if (emit) tog <= ~tog;
        if (vld_sr[1] && (dout != exp_sr[1]) && (err_count != {CW{1'b1}}))
          err_count <= err_count + 1'b1;
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_chain_exerciser.sv
// Self-checking bench: 2-cycle loopback stage with random bit inversions, checked against a window-count model.
module tb_chain_exerciser;

  localparam int LEN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        test_sel = 1'b0;
  logic        mode = 1'b0;
  logic        din, test, dout, busy, done, pass;
  logic [15:0] err_count;
  logic        din_s, test_s, dout_s, busy_s, done_s, pass_s;
  logic [1:0]  err_s;

  logic p0 = 1'b0, p1 = 1'b0, q0 = 1'b0, q1 = 1'b0;
  logic stuck = 1'b0;
  logic inv = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chain_exerciser #(.LEN(LEN), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .test_sel(test_sel), .mode(mode),
    .din(din), .test(test), .dout(dout), .busy(busy), .done(done),
    .err_count(err_count), .pass(pass)
  );

  chain_exerciser #(.LEN(LEN), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .test_sel(test_sel), .mode(mode),
    .din(din_s), .test(test_s), .dout(dout_s), .busy(busy_s), .done(done_s),
    .err_count(err_s), .pass(pass_s)
  );

  // Downstream stage: two registers, optional stuck-at-0 or per-cycle inversion.
  always @(posedge clk) begin
    p0 <= din;
    p1 <= p0;
    q0 <= din_s;
    q1 <= q0;
  end
  assign dout   = stuck ? 1'b0 : (p1 ^ inv);
  assign dout_s = ~q1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_din"}, din, 0);
    check({tag, "_test"}, test, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_err_sat"}, err_s, 0);
    check({tag, "_busy_sat"}, busy_s, 0);
  endtask

  // One run: accept at edge 0, done expected exactly at edge LEN+3.
  task automatic run(input logic sel, input bit stuck_i, input bit inject, input bit extra_start);
    int exp_err;
    int exp_sat;
    exp_err = 0;
    @(negedge clk);
    start = 1'b1;
    test_sel = sel;
    stuck = stuck_i;
    @(posedge clk); #1;
    start = 1'b0;
    test_sel = $urandom_range(0, 1);
    check("test_latched", test, sel);
    check("busy_run", busy, 1);
    for (int c = 1; c <= LEN + 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (extra_start && c == 4) begin
        start = 1'b1;
        test_sel = ~sel;
      end
      inv = inject ? ($urandom_range(0, 3) == 0) : 1'b0;
      // Only dout cycles carrying pattern bits 0..LEN-1 are compared.
      if (inv && c >= 3 && c <= LEN + 2) exp_err++;
      if (c <= LEN) check("din_pattern", din, ((c - 1) % 2 == 0) ? 1 : 0);
      else          check("din_idle", din, 0);
      check("test_hold", test, sel);
      if (c == LEN + 2) begin
        check("done_early", done, 0);
        check("busy_drain", busy, 1);
      end
    end
    inv = 1'b0;
    if (stuck_i) begin
      exp_err = 0;
      for (int k = 0; k < LEN; k++) if (k % 2 == 0) exp_err++;
    end
    exp_sat = (LEN > 3) ? 3 : LEN;
    check("done_edge", done, 1);
    check("busy_done", busy, 0);
    check("err_count", err_count, exp_err);
    check("pass", pass, (exp_err == 0) ? 1 : 0);
    check("err_sat", err_s, exp_sat);
    check("pass_sat", pass_s, 0);
    @(posedge clk); #1;
    check("err_stable", err_count, exp_err);
    check("done_stable", done, 1);
    $display("run sel=%0d stuck=%0d inject=%0d extra_start=%0d err=%0d exp=%0d sat=%0d",
             sel, stuck_i, inject, extra_start, err_count, exp_err, err_s);
    stuck = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    run(1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b1);
    for (int r = 0; r < 4; r++)
      run(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // Reset in RUN cycle 7 aborts the run immediately.
    @(negedge clk);
    start = 1'b1;
    test_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_rst");
    $display("reset mid-run: outputs cleared, state idle");
    run(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chain_exerciser.md
CHAIN_EXERCISER -- requirements
Module: chain_exerciser

Interface
- REQ-001 SHALL have parameter LEN, default 256: number of pattern bits driven per run (2..65535).
- REQ-002 SHALL have parameter CW, default 16: width of the error counter.
- REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port start, input, 1: run request, sampled on posedge.
- REQ-006 SHALL have port test_sel, input, 1: chain-path select, latched at run start.
- REQ-007 SHALL have port mode, input, 1: pattern select (0 = toggle, 1 = LFSR), latched at run start.
- REQ-008 SHALL have port din, output, 1: registered pattern bit to the downstream delay-chain stage.
- REQ-009 SHALL have port test, output, 1: registered path select to the downstream stage.
- REQ-010 SHALL have port dout, input, 1: registered result returned from the downstream stage.
- REQ-011 SHALL have port busy, output, 1: high in RUN and DRAIN.
- REQ-012 SHALL have port done, output, 1: high in DONE.
- REQ-013 SHALL have port err_count, output, CW: mismatch count for the current or last run.
- REQ-014 SHALL have port pass, output, 1: equals done AND (err_count == 0).

Function
- REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
- REQ-016 SHALL accept start only in IDLE or DONE; on acceptance it SHALL latch test_sel/mode, clear err_count, load the pattern generator, and go to RUN; start in RUN or DRAIN SHALL be ignored.
- REQ-017 SHALL drive exactly LEN pattern bits on din, one per cycle, in the LEN cycles after acceptance, then go to DRAIN.
- REQ-018 SHALL use a toggle pattern whose first bit is 1 and which alternates every cycle thereafter.
- REQ-019 SHALL hold din at 0 in IDLE, DRAIN and DONE.
- REQ-020 SHALL drive test from the latched test_sel from the cycle after acceptance and hold it until the next acceptance.
- REQ-021 SHALL model the downstream latency as exactly 2 cycles: dout at cycle t+2 is expected to equal din at cycle t.
- REQ-022 SHALL implement the comparison with a 2-deep expected-bit shift register plus a 2-deep valid shift register, so exactly LEN samples are compared.
- REQ-023 SHALL increment err_count on each mismatch.
- REQ-024 SHALL saturate err_count at 2^CW-1 with no wrap-around.
- REQ-025 SHALL stay in DRAIN for exactly 2 cycles, then enter DONE; done SHALL first assert LEN+3 posedges after the accepting edge.
- REQ-026 SHALL hold err_count and pass stable in DONE until the next acceptance.
- REQ-027 SHALL, when start is asserted in the same cycle DONE is entered, ignore it, because the FSM is still in DRAIN.

Reset
- REQ-028 SHALL, on rst_n low, asynchronously force state=IDLE, din=0, test=0, busy=0, done=0, pass=0, err_count=0, the shift registers to 0, and the LFSR to its seed.
- REQ-029 SHALL, if reset occurs mid-run, abort the run with no residual comparisons after release; the first cycle after release SHALL be IDLE.

Configuration
- REQ-030 SHALL, with macro CHAIN_EXERCISER_LFSR_EN defined, compile in an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01, din = bit 0, advancing once per RUN cycle) used when the latched mode=1.
- REQ-031 SHALL, without CHAIN_EXERCISER_LFSR_EN, contain no LFSR logic, ignore mode, and always use the toggle pattern.

Verification
- REQ-032 SHALL test ideal 2-cycle loopback model, LEN=16, toggle -> done at edge 19 after acceptance, err_count=0, pass=1.
- REQ-033 SHALL test LEN=16, toggle, dout stuck at 0 -> err_count=8, pass=0.
- REQ-034 SHALL test loopback with dout inverted on 3 compared cycles -> err_count=3.
- REQ-035 SHALL test CW=2, LEN=16, dout always inverted -> err_count saturates at 3.
- REQ-036 SHALL test start pulsed in RUN cycle 5 -> ignored, done still at edge 19; test tracks test_sel latched at acceptance only.
- REQ-037 SHALL test rst_n low in RUN cycle 7 -> all outputs 0 immediately; a new start then yields a clean run with err_count=0 (LFSR_EN build: LEN=8 mode=1 din sequence starts 1,0,0,0,...).
